// File: rtl/gpio_port_if.sv
// Register-bus interface for gpio_port: single-cycle request channel plus
// a one-cycle-later read response channel.
interface gpio_port_if;
   logic       req_valid;
   logic       req_wr;
   logic [2:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;

   modport master (output req_valid, req_wr, req_addr, req_wdata,
                   input  rsp_valid, rsp_rdata);
   modport slave  (input  req_valid, req_wr, req_addr, req_wdata,
                   output rsp_valid, rsp_rdata);
endinterface

// File: rtl/gpio_port.sv
// 8-bit GPIO port: synchronized inputs with edge events/irq, set/clr/toggle outputs.
// Optional input glitch filter enabled by defining GPIO_PORT_DEBOUNCE_EN.
module gpio_port #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  input_pins,
   output logic [7:0]  output_pins,
   output logic        irq,
   gpio_port_if.slave  bus
);

`ifdef GPIO_PORT_DEBOUNCE_EN
   localparam int ARM_CYCLES = SYNC_STAGES + 1 + 4;
`else
   localparam int ARM_CYCLES = SYNC_STAGES + 1;
`endif
   localparam logic [3:0] ARM_LAST = 4'(ARM_CYCLES);

   logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
   logic [7:0] in_s;
   logic [7:0] out_q, out_d;
   logic [7:0] rise_q, rise_d;
   logic [7:0] fall_q, fall_d;
   logic [7:0] evt_q, evt_d;
   logic [7:0] in_prev_q, in_prev_d;
   logic [3:0] arm_q, arm_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [7:0] rsp_rdata_q, rsp_rdata_d;
   logic       irq_q, irq_d;
   logic       wr_s, rd_s, armed_s;
   logic [7:0] set_s, clr_s;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], input_pins};
   end

`ifdef GPIO_PORT_DEBOUNCE_EN
   logic [7:0]      flt_q, flt_d;
   logic [7:0][1:0] dcnt_q, dcnt_d;

   // The filter output follows only after four consecutive differing samples.
   always_comb begin
      flt_d  = flt_q;
      dcnt_d = dcnt_q;
      for (int i = 0; i < 8; i++) begin
         if (sync_q[SYNC_STAGES-1][i] == flt_q[i]) begin
            dcnt_d[i] = 2'd0;
         end else if (dcnt_q[i] == 2'd3) begin
            flt_d[i]  = sync_q[SYNC_STAGES-1][i];
            dcnt_d[i] = 2'd0;
         end else begin
            dcnt_d[i] = dcnt_q[i] + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flt_q  <= 8'h00;
         dcnt_q <= '0;
      end else begin
         flt_q  <= flt_d;
         dcnt_q <= dcnt_d;
      end
   end

   assign in_s = flt_q;
`else
   assign in_s = sync_q[SYNC_STAGES-1];
`endif

   always_comb begin
      wr_s    = bus.req_valid & bus.req_wr;
      rd_s    = bus.req_valid & ~bus.req_wr;
      out_d   = out_q;
      rise_d  = rise_q;
      fall_d  = fall_q;
      clr_s   = 8'h00;
      rsp_valid_d = rd_s;
      rsp_rdata_d = 8'h00;
      in_prev_d   = in_s;
      irq_d       = |evt_q;

      // Edges are ignored until the input pipeline has filled after reset.
      armed_s = (arm_q == ARM_LAST);
      if (armed_s) begin
         arm_d = arm_q;
         set_s = (in_s & ~in_prev_q & rise_q) | (~in_s & in_prev_q & fall_q);
      end else begin
         arm_d = arm_q + 4'd1;
         set_s = 8'h00;
      end

      if (wr_s) begin
         case (bus.req_addr)
            3'd0:    out_d  = bus.req_wdata;
            3'd2:    rise_d = bus.req_wdata;
            3'd3:    fall_d = bus.req_wdata;
            3'd4:    clr_s  = bus.req_wdata;
            3'd5:    out_d  = out_q | bus.req_wdata;
            3'd6:    out_d  = out_q & ~bus.req_wdata;
            3'd7:    out_d  = out_q ^ bus.req_wdata;
            default: out_d  = out_q;
         endcase
      end else begin
         out_d = out_q;
      end

      // A new edge wins over a simultaneous write-1-to-clear.
      evt_d = (evt_q & ~clr_s) | set_s;

      if (rd_s) begin
         case (bus.req_addr)
            3'd1:    rsp_rdata_d = in_s;
            3'd2:    rsp_rdata_d = rise_q;
            3'd3:    rsp_rdata_d = fall_q;
            3'd4:    rsp_rdata_d = evt_q;
            default: rsp_rdata_d = out_q;
         endcase
      end else begin
         rsp_rdata_d = 8'h00;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q      <= '0;
         out_q       <= 8'h00;
         rise_q      <= 8'h00;
         fall_q      <= 8'h00;
         evt_q       <= 8'h00;
         in_prev_q   <= 8'h00;
         arm_q       <= 4'd0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 8'h00;
         irq_q       <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         out_q       <= out_d;
         rise_q      <= rise_d;
         fall_q      <= fall_d;
         evt_q       <= evt_d;
         in_prev_q   <= in_prev_d;
         arm_q       <= arm_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         irq_q       <= irq_d;
      end
   end

   assign output_pins   = out_q;
   assign irq           = irq_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;

endmodule
